// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage PC controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Instruction fetch is word-aligned; low two address bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register and redirect controller fed by the BTB: chooses sequential,
// predicted or corrected next PC, drives pipeline flushes and keeps statistics.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          RECOVER_N = 2,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_id_i,
  input  logic             hit_i,
  input  logic             mis_hit_i,
  input  logic [31:0]      predicted_pc_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_four_o,
  output logic             valid_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int              REC_W    = (RECOVER_N > 1) ? $clog2(RECOVER_N) : 1;
  localparam logic [REC_W-1:0] REC_LOAD = REC_W'(RECOVER_N - 1);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_seq;
  logic [REC_W-1:0] rec_q;
  logic             valid_q;
  logic             mis_accept;
  logic             hit_accept;
  logic             branch_en;

  // A mispredict correction wins over a stall; a prediction waits for the stall to clear.
  assign mis_accept = (state_q == RUN) && mis_hit_i;
  assign hit_accept = (state_q == RUN) && hit_i && !stall_i && !mis_hit_i;
  assign branch_en  = (state_q == RUN) && branch_id_i && !stall_i && !mis_hit_i;
  assign pc_seq     = pc_q + 32'd4;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pc_d       = pc_q;
    flush_if_o = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    if (mis_accept) begin
      pc_d       = align_pc(predicted_pc_i);
      flush_if_o = 1'b1;
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (hit_accept) begin
      pc_d       = align_pc(predicted_pc_i);
      flush_if_o = 1'b1;
    end else if ((state_q != BOOT) && !stall_i) begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= align_pc(RESET_PC);
      rec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (mis_accept) begin
            state_q <= RECOVER;
            rec_q   <= REC_LOAD;
          end
        end
        RECOVER: begin
          if (rec_q == '0) begin
            state_q <= RUN;
          end else begin
            rec_q <= rec_q - 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (branch_en),
    .cnt_o (branch_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (mis_accept),
    .cnt_o (mispred_cnt_o)
  );

  assign pc_o      = pc_q;
  assign pc_four_o = pc_seq;
  assign valid_o   = valid_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: sequential fetch, redirects, recovery, counters, reset.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_id, hit, mis_hit;
  logic [31:0] pred_pc;

  logic [31:0] pc, pc_four;
  logic        valid, fl_if, fl_id, fl_ex;
  logic [2:0]  br_cnt, mp_cnt;

  logic [31:0] w_pc, w_pc_four;
  logic        w_valid, w_fl_if, w_fl_id, w_fl_ex;
  logic [31:0] w_br_cnt, w_mp_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .RECOVER_N(2), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_id_i(branch_id),
    .hit_i(hit), .mis_hit_i(mis_hit), .predicted_pc_i(pred_pc),
    .pc_o(pc), .pc_four_o(pc_four), .valid_o(valid),
    .flush_if_o(fl_if), .flush_id_o(fl_id), .flush_ex_o(fl_ex),
    .branch_cnt_o(br_cnt), .mispred_cnt_o(mp_cnt)
  );

  fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC), .RECOVER_N(2), .CNT_W(32)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_id_i(branch_id),
    .hit_i(hit), .mis_hit_i(mis_hit), .predicted_pc_i(pred_pc),
    .pc_o(w_pc), .pc_four_o(w_pc_four), .valid_o(w_valid),
    .flush_if_o(w_fl_if), .flush_id_o(w_fl_id), .flush_ex_o(w_fl_ex),
    .branch_cnt_o(w_br_cnt), .mispred_cnt_o(w_mp_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_id = 1'b0; hit = 1'b0; mis_hit = 1'b0; pred_pc = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    tests_run++;
    if (pc !== 32'h0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h valid=%b, expected pc=00000000 valid=0", pc, valid);
    end
    tests_run++;
    if (br_cnt !== 3'd0 || mp_cnt !== 3'd0 || {fl_if, fl_id, fl_ex} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_counters: br=%0d mp=%0d flush=%b, expected 0 0 000", br_cnt, mp_cnt,
               {fl_if, fl_id, fl_ex});
    end
    tests_run++;
    if (w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pc_param: pc=%h valid=%b, expected fffffffc 0", w_pc, w_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    step();  // BOOT -> RUN, PC held
    tests_run++;
    if (pc !== 32'h0 || valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL boot_exit: pc=%h valid=%b wrap_pc=%h, expected 00000000 1 fffffffc",
               pc, valid, w_pc);
    end
    tests_run++;
    if (w_pc_four !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_four_wrap: got %h expected 00000000", w_pc_four);
    end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      tests_run++;
      if (pc !== exp_pc || {fl_if, fl_id, fl_ex} !== 3'b000) begin
        tests_failed++;
        $display("FAIL seq_pc[%0d]: pc=%h flush=%b, expected pc=%h flush=000", i, pc,
                 {fl_if, fl_id, fl_ex}, exp_pc);
      end
      if (i == 0) begin
        tests_run++;
        if (w_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL pc_wrap: got %h expected 00000000", w_pc);
        end
      end
    end
  endtask

  task automatic test_predicted_redirect();
    hit = 1'b1; pred_pc = 32'h20;
    #1;
    tests_run++;
    if (fl_if !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_to_20_flush: flush_if=%b expected 1", fl_if);
    end
    step();
    tests_run++;
    if (pc !== 32'h20) begin
      tests_failed++;
      $display("FAIL hit_to_20_pc: got %h expected 00000020", pc);
    end
    stall = 1'b1; hit = 1'b1; pred_pc = 32'h100;
    #1;
    tests_run++;
    if ({fl_if, fl_id, fl_ex} !== 3'b000) begin
      tests_failed++;
      $display("FAIL hit_stalled_flush: flush=%b expected 000", {fl_if, fl_id, fl_ex});
    end
    step();
    tests_run++;
    if (pc !== 32'h20) begin
      tests_failed++;
      $display("FAIL hit_stalled_pc: got %h expected 00000020", pc);
    end
    stall = 1'b0;
    #1;
    tests_run++;
    if ({fl_if, fl_id, fl_ex} !== 3'b100) begin
      tests_failed++;
      $display("FAIL hit_flush: flush=%b expected 100", {fl_if, fl_id, fl_ex});
    end
    step();
    hit = 1'b0;
    #1;
    tests_run++;
    if (pc !== 32'h100 || pc_four !== 32'h104 || fl_if !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_pc: pc=%h pc_four=%h flush_if=%b, expected 00000100 00000104 0",
               pc, pc_four, fl_if);
    end
  endtask

  task automatic test_mispredict();
    mis_hit = 1'b1; hit = 1'b1; stall = 1'b1; branch_id = 1'b1; pred_pc = 32'h44;
    #1;
    tests_run++;
    if ({fl_if, fl_id, fl_ex} !== 3'b111) begin
      tests_failed++;
      $display("FAIL mis_flush: flush=%b expected 111", {fl_if, fl_id, fl_ex});
    end
    step();
    tests_run++;
    if (pc !== 32'h44 || mp_cnt !== 3'd1 || br_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL mis_pc_cnt: pc=%h mp=%0d br=%0d, expected 00000044 1 0", pc, mp_cnt, br_cnt);
    end
    // First recovery cycle: a fresh prediction must be ignored.
    mis_hit = 1'b0; hit = 1'b1; stall = 1'b0; pred_pc = 32'h200;
    #1;
    tests_run++;
    if ({fl_if, fl_id, fl_ex} !== 3'b000 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL recover1_flush: flush=%b valid=%b, expected 000 1", {fl_if, fl_id, fl_ex},
               valid);
    end
    step();
    tests_run++;
    if (pc !== 32'h48) begin
      tests_failed++;
      $display("FAIL recover1_pc: got %h expected 00000048", pc);
    end
    // Second recovery cycle: a mispredict is ignored as well.
    mis_hit = 1'b1;
    #1;
    tests_run++;
    if ({fl_if, fl_id, fl_ex} !== 3'b000) begin
      tests_failed++;
      $display("FAIL recover2_flush: flush=%b expected 000", {fl_if, fl_id, fl_ex});
    end
    step();
    tests_run++;
    if (pc !== 32'h4C || mp_cnt !== 3'd1 || br_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL recover2_pc_cnt: pc=%h mp=%0d br=%0d, expected 0000004c 1 0", pc, mp_cnt,
               br_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_misaligned();
    hit = 1'b1; pred_pc = 32'h103;
    #1;
    tests_run++;
    if (fl_if !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_resumed_flush: flush_if=%b expected 1", fl_if);
    end
    step();
    tests_run++;
    if (pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL misaligned_pc: got %h expected 00000100", pc);
    end
    idle_inputs();
  endtask

  task automatic test_counters();
    logic [2:0] exp_cnt;
    branch_id = 1'b1; stall = 1'b1;
    step();
    tests_run++;
    if (br_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL branch_stalled: br=%0d expected 0", br_cnt);
    end
    stall = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_cnt = (i > 7) ? 3'd7 : 3'(i);
      tests_run++;
      if (br_cnt !== exp_cnt) begin
        tests_failed++;
        $display("FAIL branch_cnt[%0d]: got %0d expected %0d", i, br_cnt, exp_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_recover();
    mis_hit = 1'b1; pred_pc = 32'h80;
    step();
    idle_inputs();
    tests_run++;
    if (pc !== 32'h80 || mp_cnt !== 3'd2) begin
      tests_failed++;
      $display("FAIL pre_reset_mis: pc=%h mp=%0d expected 00000080 2", pc, mp_cnt);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (pc !== 32'h0 || valid !== 1'b0 || br_cnt !== 3'd0 || mp_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h valid=%b br=%0d mp=%0d, expected 00000000 0 0 0",
               pc, valid, br_cnt, mp_cnt);
    end
    #1;
    rst = 1'b0;
    hit = 1'b1; pred_pc = 32'h300;  // BOOT must ignore this
    #1;
    tests_run++;
    if (fl_if !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_ignores_hit: flush_if=%b expected 0", fl_if);
    end
    step();
    hit = 1'b0;
    tests_run++;
    if (pc !== 32'h0 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_boot: pc=%h valid=%b expected 00000000 1", pc, valid);
    end
    step();
    tests_run++;
    if (pc !== 32'h4) begin
      tests_failed++;
      $display("FAIL post_reset_pc4: got %h expected 00000004", pc);
    end
    step();
    tests_run++;
    if (pc !== 32'h8) begin
      tests_failed++;
      $display("FAIL post_reset_pc8: got %h expected 00000008", pc);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_predicted_redirect();
    test_mispredict();
    test_misaligned();
    test_counters();
    test_reset_mid_recover();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
